// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared state encodings and constants for the envelope follower
// Used by env_mag and envelope_follower.
package adsr_pkg;

  localparam int ENV_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_ON   = 3'b010,
    ST_HOLD = 3'b100
  } env_state_e;

  localparam logic [ENV_WIDTH-1:0] MID     = 12'd2048;
  localparam logic [ENV_WIDTH-1:0] MAG_MAX = 12'd4094;

  function automatic logic [ENV_WIDTH-1:0] min_level(input logic [ENV_WIDTH-1:0] a,
                                                     input logic [ENV_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/env_mag.sv
// rtl/env_mag.sv - S1 stage: offset-binary sample to saturated, doubled magnitude
// Registers magnitude and its valid; magnitude holds between strobes.
module env_mag
  import adsr_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_in,
  input  logic [WIDTH-1:0] wave_in,
  output logic             mag_valid,
  output logic [WIDTH-1:0] mag
);

  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   abs_d;
  logic [WIDTH-1:0] mag_d, mag_q;
  logic             valid_d, valid_q;

  always_comb begin
    diff    = {1'b0, wave_in} - {1'b0, MID};
    abs_d   = diff[WIDTH] ? (~diff + 13'd1) : diff;
    valid_d = en_in;
    mag_d   = mag_q;
    if (en_in) begin
      // |d| of 2048 only occurs for sample 0 and clips to the same 4094 as 2047
      mag_d = (abs_d > 13'd2047) ? MAG_MAX : WIDTH'(abs_d << 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      mag_q   <= mag_d;
    end
  end

  assign mag_valid = valid_q;
  assign mag       = mag_q;

endmodule

// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - envelope tracker and hysteretic gate (S2) over the env_mag stage
// Optional peak register when ENV_FOLLOWER_PEAK_EN is defined.
module envelope_follower
  import adsr_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int HOLD_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [WIDTH-1:0]  wave_in,
  input  logic [3:0]        attack_shift,
  input  logic [3:0]        release_shift,
  input  logic [WIDTH-1:0]  on_thresh,
  input  logic [WIDTH-1:0]  off_thresh,
  input  logic [HOLD_W-1:0] hold_time,
`ifdef ENV_FOLLOWER_PEAK_EN
  input  logic              peak_clr,
  output logic [WIDTH-1:0]  peak,
`endif
  output logic [WIDTH-1:0]  envelope,
  output logic              gate,
  output logic              en_out
);

  logic             mag_valid;
  logic [WIDTH-1:0] mag_s1;

  env_mag #(
    .WIDTH(WIDTH)
  ) u_env_mag (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_in    (en_in),
    .wave_in  (wave_in),
    .mag_valid(mag_valid),
    .mag      (mag_s1)
  );

  logic [WIDTH-1:0]  env_d, env_q;
  logic              gate_d, gate_q;
  logic              en_out_d, en_out_q;
  logic [HOLD_W-1:0] cnt_d, cnt_q;
  env_state_e        state_d, state_q;

  logic [WIDTH:0]    delta;
  logic [WIDTH:0]    step;
  logic [WIDTH-1:0]  env_new;
  logic [WIDTH-1:0]  off_eff;

  // Step is at least 1 and at most the gap, so env lands on mag rather than crossing it.
  always_comb begin
    delta   = '0;
    step    = '0;
    env_new = env_q;
    if (mag_s1 > env_q) begin
      delta = {1'b0, mag_s1} - {1'b0, env_q};
      step  = delta >> attack_shift;
      if (step == '0) begin
        step = 13'd1;
      end
      env_new = (step >= delta) ? mag_s1 : WIDTH'({1'b0, env_q} + step);
    end else if (mag_s1 < env_q) begin
      delta = {1'b0, env_q} - {1'b0, mag_s1};
      step  = delta >> release_shift;
      if (step == '0) begin
        step = 13'd1;
      end
      env_new = (step >= delta) ? mag_s1 : WIDTH'({1'b0, env_q} - step);
    end
  end

  assign off_eff = min_level(off_thresh, on_thresh);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mag_valid && (env_new >= on_thresh)) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (mag_valid && (env_new < off_eff)) begin
          state_d = ST_HOLD;
          cnt_d   = hold_time;
        end
      end
      ST_HOLD: begin
        if (mag_valid) begin
          if (env_new >= on_thresh) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    env_d    = env_q;
    gate_d   = gate_q;
    en_out_d = 1'b0;
    if (mag_valid) begin
      env_d    = env_new;
      gate_d   = (state_d != ST_IDLE);
      en_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q    <= '0;
      gate_q   <= 1'b0;
      en_out_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      env_q    <= env_d;
      gate_q   <= gate_d;
      en_out_q <= en_out_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign envelope = env_q;
  assign gate     = gate_q;
  assign en_out   = en_out_q;

`ifdef ENV_FOLLOWER_PEAK_EN
  logic [WIDTH-1:0] peak_d, peak_q;

  // A clear coinciding with an update restarts the peak from the new envelope.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = mag_valid ? env_new : '0;
    end else if (mag_valid && (env_new > peak_q)) begin
      peak_d = env_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - self-checking bench for envelope_follower
// Directed scenarios followed by randomized streaming against a per-sample reference model.
module tb_envelope_follower;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic [11:0] wave_in;
  logic [3:0]  attack_shift;
  logic [3:0]  release_shift;
  logic [11:0] on_thresh;
  logic [11:0] off_thresh;
  logic [11:0] hold_time;
  logic [11:0] envelope;
  logic        gate;
  logic        en_out;
`ifdef ENV_FOLLOWER_PEAK_EN
  logic [11:0] peak_w;
`endif

  always #5 clk = ~clk;

  envelope_follower dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_in        (en_in),
    .wave_in      (wave_in),
    .attack_shift (attack_shift),
    .release_shift(release_shift),
    .on_thresh    (on_thresh),
    .off_thresh   (off_thresh),
    .hold_time    (hold_time),
`ifdef ENV_FOLLOWER_PEAK_EN
    .peak_clr     (1'b0),
    .peak         (peak_w),
`endif
    .envelope     (envelope),
    .gate         (gate),
    .en_out       (en_out)
  );

  int vectors = 0;
  int miscompares = 0;

  localparam int M_IDLE = 0;
  localparam int M_ON   = 1;
  localparam int M_HOLD = 2;

  int m_env, m_gate, m_en_out, m_mode, m_cnt, m_s1_v, m_s1_mag;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input int w);
    int d;
    d = w - 2048;
    if (d < 0) d = -d;
    if (d > 2047) d = 2047;
    return d * 2;
  endfunction

  task automatic model_reset();
    m_env = 0; m_gate = 0; m_en_out = 0; m_mode = M_IDLE; m_cnt = 0;
    m_s1_v = 0; m_s1_mag = 0;
  endtask

  task automatic model_s2(input int mag);
    int s, ont, offe;
    if (mag > m_env) begin
      s = (mag - m_env) >> int'(attack_shift);
      if (s < 1) s = 1;
      m_env = m_env + s;
      if (m_env > mag) m_env = mag;
    end else if (mag < m_env) begin
      s = (m_env - mag) >> int'(release_shift);
      if (s < 1) s = 1;
      m_env = m_env - s;
      if (m_env < mag) m_env = mag;
    end
    ont  = int'(on_thresh);
    offe = (int'(off_thresh) < ont) ? int'(off_thresh) : ont;
    if (m_mode == M_IDLE) begin
      if (m_env >= ont) m_mode = M_ON;
    end else if (m_mode == M_ON) begin
      if (m_env < offe) begin
        m_mode = M_HOLD;
        m_cnt  = int'(hold_time);
      end
    end else begin
      if (m_env >= ont) m_mode = M_ON;
      else if (m_cnt == 0) m_mode = M_IDLE;
      else m_cnt = m_cnt - 1;
    end
    m_gate = (m_mode != M_IDLE) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_env"}, 32'(envelope), m_env);
    check({tag, "_gate"}, 32'(gate), m_gate);
    check({tag, "_en_out"}, 32'(en_out), m_en_out);
  endtask

  task automatic step(input bit en, input int w, input string tag);
    en_in   = en;
    wave_in = 12'(w);
    @(posedge clk);
    if (m_s1_v != 0) begin
      model_s2(m_s1_mag);
      m_en_out = 1;
    end else begin
      m_en_out = 0;
    end
    m_s1_v   = en ? 1 : 0;
    m_s1_mag = mag_of(w);
    #1;
    check_outputs(tag);
  endtask

  task automatic sample(input int w, input string tag);
    step(1'b1, w, {tag, "_s1"});
    step(1'b0, 0, tag);
  endtask

  initial begin
    rst_n = 1'b0; en_in = 1'b0; wave_in = 12'd2048;
    attack_shift = 4'd0; release_shift = 4'd0;
    on_thresh = 12'd1000; off_thresh = 12'd500; hold_time = 12'd3;
    model_reset();

    // Reset held with strobes toggling
    for (int i = 0; i < 6; i++) begin
      en_in   = i[0];
      wave_in = 12'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
      check("rst_env", 32'(envelope), 0);
      check("rst_gate", 32'(gate), 0);
      check("rst_en_out", 32'(en_out), 0);
    end
    rst_n = 1'b1;
    en_in = 1'b0;
    model_reset();
    step(1'b0, 2048, "idle");

    // Attack at full rate
    step(1'b1, 4095, "atk0");
    step(1'b1, 4095, "atk1");
    check("attack_env_4094", 32'(envelope), 4094);
    check("attack_en_out", 32'(en_out), 1);
    step(1'b1, 4095, "atk2");
    step(1'b0, 2048, "atk3");
    step(1'b0, 2048, "atk4");
    check("attack_en_out_low", 32'(en_out), 0);

    // Hysteresis: drain to 0 first, then 1200 -> 0 and count hold samples
    sample(2048, "drain");
    for (int i = 0; i < 5; i++) sample(2048, "drain_h");
    check("drain_gate", 32'(gate), 0);
    sample(2648, "hyst_up");
    check("hyst_env_1200", 32'(envelope), 1200);
    check("hyst_gate_on", 32'(gate), 1);
    sample(2048, "hyst_down");
    check("hyst_env_0", 32'(envelope), 0);
    check("hyst_gate_hold0", 32'(gate), 1);
    for (int i = 0; i < 3; i++) begin
      sample(2048, "hyst_hold");
      check("hyst_gate_hold", 32'(gate), 1);
    end
    sample(2048, "hyst_drop");
    check("hyst_gate_drop", 32'(gate), 0);

    // Re-trigger from HOLD reloads the hold count on the next fall
    sample(2648, "rt_up");
    sample(2048, "rt_hold");
    sample(2048, "rt_hold2");
    sample(0, "rt_kick");
    check("rt_env_4094", 32'(envelope), 4094);
    check("rt_gate", 32'(gate), 1);
    sample(2048, "rt_fall");
    for (int i = 0; i < 3; i++) begin
      sample(2048, "rt_hold_again");
      check("rt_gate_hold", 32'(gate), 1);
    end
    sample(2048, "rt_drop");
    check("rt_gate_drop", 32'(gate), 0);

    // Minimum step of 1 without crossing mag
    sample(2053, "ms_up");
    check("ms_env_10", 32'(envelope), 10);
    release_shift = 4'd15;
    sample(2052, "ms_dn1");
    check("ms_env_9", 32'(envelope), 9);
    sample(2052, "ms_dn2");
    sample(2052, "ms_dn3");
    check("ms_env_8", 32'(envelope), 8);
    release_shift = 4'd0;

    // Asynchronous reset between clock edges while in HOLD
    sample(2648, "ar_up");
    sample(2048, "ar_hold");
    check("ar_gate_hold", 32'(gate), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_env", 32'(envelope), 0);
    check("ar_gate", 32'(gate), 0);
    check("ar_en_out", 32'(en_out), 0);
    rst_n = 1'b1;
    model_reset();
    sample(2048, "ar_restart");
    check("ar_restart_gate", 32'(gate), 0);

    // on_thresh = 0 raises the gate on the first sample
    on_thresh = 12'd0; off_thresh = 12'd0;
    sample(2048, "on0");
    check("on0_gate", 32'(gate), 1);

    // Randomized streaming
    for (int i = 0; i < 800; i++) begin
      if ((i % 50) == 0) begin
        attack_shift  = 4'($urandom_range(0, 15));
        release_shift = 4'($urandom_range(0, 15));
        on_thresh     = 12'($urandom_range(0, 4095));
        off_thresh    = 12'($urandom_range(0, 4095));
        hold_time     = 12'($urandom_range(0, 6));
        if ((i % 100) == 0) begin
          attack_shift  = 4'($urandom_range(0, 2));
          release_shift = 4'($urandom_range(0, 2));
        end
      end
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)), "rand");
    end
    step(1'b0, 2048, "tail0");
    step(1'b0, 2048, "tail1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
